// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, jump opcode class and condition codes for the fetch sequencer
package fetch_pkg;
  typedef enum logic {FETCH_OP = 1'b0, FETCH_ARG = 1'b1} state_t;
  localparam logic [3:0] JMP_CLASS_DEF = 4'hF;
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_NZ     = 2'b11;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: PC/ROM/decoder bundle; slave = sequencer, master = PC+ROM+ALU side; halted exists only with FETCH_HALT_EN
interface fetch_sequencer_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] jump_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic              stall;
  logic              flag_z;
  logic              flag_c;
  logic              PCincr;
  logic              instr_valid;
`ifdef FETCH_HALT_EN
  logic              halted;
`endif
  modport slave (
    input  pc, rom_data, stall, flag_z, flag_c,
    output PCincr, jump_addr, instr, instr_valid
`ifdef FETCH_HALT_EN
    , output halted
`endif
  );
  modport master (
    output pc, rom_data, stall, flag_z, flag_c,
    input  PCincr, jump_addr, instr, instr_valid
`ifdef FETCH_HALT_EN
    , input halted
`endif
  );
endinterface

// File: rtl/fetch_sequencer_jump_cond.sv
// jump_cond: decides whether a conditional jump is taken from cond[1:0] and the ALU flags
module jump_cond
  import fetch_pkg::*;
(
  input  logic [1:0] cond,
  input  logic       flag_z,
  input  logic       flag_c,
  output logic       take
);
  always_comb take = cond == COND_ALWAYS ? 1'b1 :
                     cond == COND_Z      ? flag_z :
                     cond == COND_C      ? flag_c : !flag_z;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: steers the PC (PCincr/jump_addr), fetches opcode/target bytes and issues instr/instr_valid; optional FETCH_HALT_EN adds halted
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [3:0]        JMP_CLASS = JMP_CLASS_DEF
)(
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.slave  bus
);
  state_t            state, state_n;
  logic [DATA_W-1:0] instr;
  logic              instr_valid, frozen, take, is_jmp, pc_incr;
  logic [ADDR_W-1:0] jaddr;
  assign is_jmp = bus.rom_data[7:4] == JMP_CLASS;
  jump_cond u_cond (.cond(instr[1:0]), .flag_z(bus.flag_z), .flag_c(bus.flag_c), .take(take));
`ifdef FETCH_HALT_EN
  logic halted, halt_hit;
  // An always-taken jump back onto its own opcode is a deliberate halt; freeze like a permanent stall.
  assign halt_hit = !frozen && state == FETCH_ARG && instr[1:0] == COND_ALWAYS &&
                    ADDR_W'(bus.rom_data) == ADDR_W'(bus.pc - 1'b1);
  assign frozen = bus.stall | halted;
  assign bus.halted = halted;
  always_ff @(posedge clk)
    if (reset) halted <= 1'b0;
    else if (halt_hit) halted <= 1'b1;
`else
  assign frozen = bus.stall;
`endif
  // The PC has no reset, so reset is a forced load of RESET_VEC.
  always_comb begin
    pc_incr = 1'b1;
    jaddr   = ADDR_W'(bus.rom_data);
    state_n = state;
    if (reset) begin
      pc_incr = 1'b0;
      jaddr   = RESET_VEC;
    end else if (frozen) begin
      pc_incr = 1'b0;
      jaddr   = bus.pc;
    end else if (state == FETCH_ARG) begin
      pc_incr = !take;
      state_n = FETCH_OP;
    end else if (is_jmp) begin
      state_n = FETCH_ARG;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state       <= FETCH_OP;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      instr_valid <= !frozen && (state == FETCH_ARG || !is_jmp);
      if (!frozen && state == FETCH_OP) instr <= bus.rom_data;
    end
  assign bus.PCincr      = pc_incr;
  assign bus.jump_addr   = jaddr;
  assign bus.instr       = instr;
  assign bus.instr_valid = instr_valid;
endmodule
